// File: rtl/wbck_ctrl.sv
// Writeback arbiter (LSU over ALU) feeding the register file write port through one
// registered stage, plus a pending-load scoreboard and load counter for dispatch stalls.
module wbck_ctrl #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int RFREG_NUM   = 32,
  parameter int LD_MAX      = 4,
  localparam int CNT_W      = $clog2(LD_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   disp_valid,
  input  logic                   disp_fire,
  input  logic                   disp_is_load,
  input  logic [RFIDX_WIDTH-1:0] disp_rd_idx,
  input  logic [RFIDX_WIDTH-1:0] disp_rs1_idx,
  input  logic [RFIDX_WIDTH-1:0] disp_rs2_idx,
  output logic                   disp_hazard,
  input  logic                   alu_wbck_valid,
  output logic                   alu_wbck_ready,
  input  logic [RFIDX_WIDTH-1:0] alu_wbck_idx,
  input  logic [XLEN-1:0]        alu_wbck_dat,
  input  logic                   lsu_wbck_valid,
  output logic                   lsu_wbck_ready,
  input  logic [RFIDX_WIDTH-1:0] lsu_wbck_idx,
  input  logic [XLEN-1:0]        lsu_wbck_dat,
  output logic                   wbck_dest_wen,
  output logic [RFIDX_WIDTH-1:0] wbck_dest_idx,
  output logic [XLEN-1:0]        wbck_dest_dat,
  output logic [CNT_W-1:0]       ld_outstanding
);

  localparam logic [CNT_W-1:0] LD_MAX_C = CNT_W'(LD_MAX);

  logic                   acc_lsu, acc_alu;
  logic                   wen_q, wen_d;
  logic [RFIDX_WIDTH-1:0] idx_q, idx_d;
  logic [XLEN-1:0]        dat_q, dat_d;
  logic                   src_lsu_q, src_lsu_d;
  logic [RFREG_NUM-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ld_set, ld_ret;

  assign lsu_wbck_ready = 1'b1;
  assign alu_wbck_ready = ~lsu_wbck_valid;
  assign acc_lsu        = lsu_wbck_valid;
  assign acc_alu        = alu_wbck_valid & ~lsu_wbck_valid;

  // idx 0 transfers are consumed (and still retire a load) but never write.
  always_comb begin
    wen_d     = 1'b0;
    idx_d     = idx_q;
    dat_d     = dat_q;
    src_lsu_d = 1'b0;
    if (acc_lsu) begin
      idx_d     = lsu_wbck_idx;
      dat_d     = lsu_wbck_dat;
      wen_d     = (lsu_wbck_idx != '0);
      src_lsu_d = 1'b1;
    end else if (acc_alu) begin
      idx_d = alu_wbck_idx;
      dat_d = alu_wbck_dat;
      wen_d = (alu_wbck_idx != '0);
    end
  end

  assign ld_set = disp_fire & disp_is_load;
  assign ld_ret = src_lsu_q;

  // Set from dispatch beats a same-cycle clear from the writeback stage.
  genvar gi;
  generate
    for (gi = 0; gi < RFREG_NUM; gi++) begin : g_pend
      if (gi == 0) begin : g_zero
        assign pend_d[gi] = 1'b0;
      end else begin : g_bit
        assign pend_d[gi] = (ld_set & (disp_rd_idx == RFIDX_WIDTH'(gi)))
                          | (pend_q[gi] & ~(wen_q & src_lsu_q & (idx_q == RFIDX_WIDTH'(gi))));
      end
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    if (ld_set && !ld_ret) begin
      if (cnt_q != LD_MAX_C) cnt_d = cnt_q + CNT_W'(1);
    end else if (!ld_set && ld_ret) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q     <= 1'b0;
      idx_q     <= '0;
      dat_q     <= '0;
      src_lsu_q <= 1'b0;
      pend_q    <= '0;
      cnt_q     <= '0;
    end else begin
      wen_q     <= wen_d;
      idx_q     <= idx_d;
      dat_q     <= dat_d;
      src_lsu_q <= src_lsu_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
    end
  end

  assign disp_hazard = disp_valid & (pend_q[disp_rs1_idx] | pend_q[disp_rs2_idx] |
                                     pend_q[disp_rd_idx] |
                                     (disp_is_load & (cnt_q == LD_MAX_C)));

  assign wbck_dest_wen  = wen_q;
  assign wbck_dest_idx  = idx_q;
  assign wbck_dest_dat  = dat_q;
  assign ld_outstanding = cnt_q;

`ifndef SYNTHESIS
  // An LSU result with no load outstanding means the LSU broke protocol.
  ld_underflow_a: assert property (@(posedge clk) disable iff (rst)
    !(ld_ret && !ld_set && cnt_q == '0));
`endif

endmodule

// File: tb/tb_wbck_ctrl.sv
// Self-checking bench for wbck_ctrl: table-driven writeback vectors through a
// scoreboard queue, plus hand-written scoreboard, counter, x0 and reset sequences.
module tb_wbck_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        disp_valid = 0, disp_fire = 0, disp_is_load = 0;
  logic [4:0]  disp_rd_idx = 0, disp_rs1_idx = 0, disp_rs2_idx = 0;
  logic        disp_hazard;
  logic        alu_wbck_valid = 0, alu_wbck_ready;
  logic [4:0]  alu_wbck_idx = 0;
  logic [31:0] alu_wbck_dat = 0;
  logic        lsu_wbck_valid = 0, lsu_wbck_ready;
  logic [4:0]  lsu_wbck_idx = 0;
  logic [31:0] lsu_wbck_dat = 0;
  logic        wbck_dest_wen;
  logic [4:0]  wbck_dest_idx;
  logic [31:0] wbck_dest_dat;
  logic [2:0]  ld_outstanding;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wbck_ctrl dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_fire(disp_fire), .disp_is_load(disp_is_load),
    .disp_rd_idx(disp_rd_idx), .disp_rs1_idx(disp_rs1_idx), .disp_rs2_idx(disp_rs2_idx),
    .disp_hazard(disp_hazard),
    .alu_wbck_valid(alu_wbck_valid), .alu_wbck_ready(alu_wbck_ready),
    .alu_wbck_idx(alu_wbck_idx), .alu_wbck_dat(alu_wbck_dat),
    .lsu_wbck_valid(lsu_wbck_valid), .lsu_wbck_ready(lsu_wbck_ready),
    .lsu_wbck_idx(lsu_wbck_idx), .lsu_wbck_dat(lsu_wbck_dat),
    .wbck_dest_wen(wbck_dest_wen), .wbck_dest_idx(wbck_dest_idx),
    .wbck_dest_dat(wbck_dest_dat), .ld_outstanding(ld_outstanding)
  );

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_idx;
    logic [31:0] alu_dat;
    logic        lsu_v;
    logic [4:0]  lsu_idx;
    logic [31:0] lsu_dat;
    logic        exp_rdy;
    logic        exp_wen;
    logic [4:0]  exp_idx;
    logic [31:0] exp_dat;
  } vec_t;

  typedef struct {
    logic        wen;
    logic [4:0]  idx;
    logic [31:0] dat;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_disp(input logic v, input logic f, input logic ld,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    disp_valid = v; disp_fire = f; disp_is_load = ld;
    disp_rd_idx = rd; disp_rs1_idx = rs1; disp_rs2_idx = rs2;
  endtask

  // Drive one writeback cycle, push the expected output, clock, then pop and compare.
  task automatic wb_step(input vec_t v, input string name);
    exp_t e;
    alu_wbck_valid = v.alu_v; alu_wbck_idx = v.alu_idx; alu_wbck_dat = v.alu_dat;
    lsu_wbck_valid = v.lsu_v; lsu_wbck_idx = v.lsu_idx; lsu_wbck_dat = v.lsu_dat;
    #1;
    chk({name, " alu_ready"}, 64'(alu_wbck_ready), 64'(v.exp_rdy));
    sb_q.push_back('{v.exp_wen, v.exp_idx, v.exp_dat});
    tick();
    e = sb_q.pop_front();
    chk({name, " wen"}, 64'(wbck_dest_wen), 64'(e.wen));
    chk({name, " idx"}, 64'(wbck_dest_idx), 64'(e.idx));
    chk({name, " dat"}, 64'(wbck_dest_dat), 64'(e.dat));
  endtask

  task automatic wb_idle();
    alu_wbck_valid = 0; lsu_wbck_valid = 0;
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 5'd3,  32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 5'd3,  32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd4,  32'h11,       1'b1, 5'd7,  32'h22,   1'b0, 1'b1, 5'd7,  32'h22};
    vecs[3] = '{1'b1, 5'd4,  32'h11,       1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 5'd4,  32'h11};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 5'd4,  32'h11};
    vecs[5] = '{1'b1, 5'd0,  32'h99,       1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 5'd0,  32'h99};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h5,    1'b0, 1'b0, 5'd0,  32'h5};
    vecs[7] = '{1'b1, 5'd12, 32'h1234,     1'b1, 5'd10, 32'hAA55, 1'b0, 1'b1, 5'd10, 32'hAA55};
    vecs[8] = '{1'b1, 5'd12, 32'h1234,     1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 5'd12, 32'h1234};

    // Reset state
    #3;
    chk("rst wen", 64'(wbck_dest_wen), 64'd0);
    chk("rst idx", 64'(wbck_dest_idx), 64'd0);
    chk("rst cnt", 64'(ld_outstanding), 64'd0);
    chk("rst hazard", 64'(disp_hazard), 64'd0);
    chk("rst lsu_ready", 64'(lsu_wbck_ready), 64'd1);
    @(negedge clk);
    rst = 0;
    tick();

    // Three loads to x0: count rises, no pend bit appears
    set_disp(1, 1, 1, 5'd0, 5'd0, 5'd0);
    tick(); tick(); tick();
    set_disp(1, 0, 0, 5'd0, 5'd0, 5'd0);
    #1;
    chk("x0 loads cnt", 64'(ld_outstanding), 64'd3);
    chk("x0 loads hazard", 64'(disp_hazard), 64'd0);
    set_disp(0, 0, 0, 5'd0, 5'd0, 5'd0);

    // Table-driven writeback vectors
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      wb_step(v, $sformatf("vec%0d", i));
    end
    wb_idle();
    tick();
    chk("table cnt drained", 64'(ld_outstanding), 64'd0);

    // Scoreboard RAW/WAW on x9
    set_disp(1, 1, 1, 5'd9, 5'd0, 5'd0);
    #1; chk("sb ld9 hazard", 64'(disp_hazard), 64'd0);
    tick();
    set_disp(1, 0, 0, 5'd0, 5'd9, 5'd0);
    #1; chk("sb raw rs1", 64'(disp_hazard), 64'd1);
    set_disp(1, 0, 0, 5'd9, 5'd0, 5'd0);
    #1; chk("sb waw rd", 64'(disp_hazard), 64'd1);
    set_disp(1, 0, 0, 5'd0, 5'd0, 5'd9);
    lsu_wbck_valid = 1; lsu_wbck_idx = 5'd9; lsu_wbck_dat = 32'h99;
    #1; chk("sb raw rs2", 64'(disp_hazard), 64'd1);
    tick();
    wb_idle();
    #1;
    chk("sb wen cycle wen", 64'(wbck_dest_wen), 64'd1);
    chk("sb wen cycle hazard", 64'(disp_hazard), 64'd1);
    tick();
    chk("sb after wen hazard", 64'(disp_hazard), 64'd0);
    chk("sb cnt", 64'(ld_outstanding), 64'd0);

    // Counter saturation at LD_MAX
    for (int r = 1; r <= 4; r++) begin
      set_disp(1, 1, 1, 5'(r), 5'd0, 5'd0);
      tick();
    end
    set_disp(1, 0, 1, 5'd5, 5'd0, 5'd0);
    #1;
    chk("cnt full", 64'(ld_outstanding), 64'd4);
    chk("cnt full load hazard", 64'(disp_hazard), 64'd1);
    set_disp(1, 0, 0, 5'd5, 5'd0, 5'd0);
    #1; chk("cnt full alu no hazard", 64'(disp_hazard), 64'd0);
    set_disp(0, 0, 0, 5'd0, 5'd0, 5'd0);
    lsu_wbck_valid = 1; lsu_wbck_idx = 5'd1; lsu_wbck_dat = 32'h1;
    tick();
    wb_idle();
    set_disp(1, 1, 1, 5'd6, 5'd0, 5'd0);   // dispatch coincides with LSU retire
    tick();
    set_disp(1, 0, 0, 5'd0, 5'd1, 5'd0);
    #1;
    chk("cnt inc+dec", 64'(ld_outstanding), 64'd4);
    chk("cnt x1 cleared", 64'(disp_hazard), 64'd0);
    set_disp(1, 0, 0, 5'd0, 5'd6, 5'd0);
    #1; chk("cnt x6 pending", 64'(disp_hazard), 64'd1);
    set_disp(0, 0, 0, 5'd0, 5'd0, 5'd0);

    // Back-to-back LSU drain, one writeback per cycle
    for (int k = 0; k < 4; k++) begin
      v = '{1'b1, 5'd20, 32'hF0F0, 1'b1, 5'(k == 3 ? 6 : k + 2), 32'(k + 100),
            1'b0, 1'b1, 5'(k == 3 ? 6 : k + 2), 32'(k + 100)};
      wb_step(v, $sformatf("drain%0d", k));
    end
    wb_idle();
    tick();
    chk("drain cnt", 64'(ld_outstanding), 64'd0);
    chk("drain wen off", 64'(wbck_dest_wen), 64'd0);

    // Asynchronous reset mid-cycle with wen = 1 and pend[5] = 1
    set_disp(1, 1, 1, 5'd5, 5'd0, 5'd0);
    alu_wbck_valid = 1; alu_wbck_idx = 5'd3; alu_wbck_dat = 32'h77;
    tick();
    set_disp(0, 0, 0, 5'd0, 5'd0, 5'd0);
    wb_idle();
    #1;
    chk("pre-rst wen", 64'(wbck_dest_wen), 64'd1);
    chk("pre-rst cnt", 64'(ld_outstanding), 64'd1);
    #1;
    rst = 1;
    #1;
    chk("async rst wen", 64'(wbck_dest_wen), 64'd0);
    chk("async rst dat", 64'(wbck_dest_dat), 64'd0);
    chk("async rst cnt", 64'(ld_outstanding), 64'd0);
    set_disp(1, 0, 0, 5'd0, 5'd5, 5'd0);
    lsu_wbck_valid = 1;
    #1;
    chk("async rst hazard", 64'(disp_hazard), 64'd0);
    chk("rst alu_ready follows lsu", 64'(alu_wbck_ready), 64'd0);
    lsu_wbck_valid = 0;
    @(negedge clk);
    rst = 0;
    tick();
    chk("post-rst hazard", 64'(disp_hazard), 64'd0);
    set_disp(0, 0, 0, 5'd0, 5'd0, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
